// File: rtl/cpu_axi_pkg.sv
// Shared types and constants for the CPU-to-AXI3 bridge.
// Holds FSM encoding, fixed AXI field values and default IDs.
package cpu_axi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    D_AR,
    D_R,
    D_AW,
    D_B,
    I_AR,
    I_R,
    DONE
  } state_t;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [3:0] LEN_1      = 4'd0;
  localparam logic [2:0] SIZE_B     = 3'd0;
  localparam logic [2:0] SIZE_H     = 3'd1;
  localparam logic [2:0] SIZE_W     = 3'd2;

  localparam logic [3:0] ID_INST_DFLT = 4'd0;
  localparam logic [3:0] ID_DATA_DFLT = 4'd1;

endpackage

// File: rtl/cpu_axi_bridge_if.sv
// Single-beat AXI3 port shared by fetch and data traffic.
// Master side is the bridge, slave side is the interconnect.
interface cpu_axi_bridge_if;

  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [3:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [1:0]  arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;

  logic [3:0]  rid;
  logic [31:0] rdata;
  logic        rvalid;
  logic        rready;

  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [3:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic [1:0]  awlock;
  logic [3:0]  awcache;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;

  logic [3:0]  wid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;

  logic        bvalid;
  logic        bready;

  modport master (
    output arid, araddr, arlen, arsize, arburst,
    output arlock, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata, rvalid,
    output rready,
    output awid, awaddr, awlen, awsize, awburst,
    output awlock, awcache, awprot, awvalid,
    input  awready,
    output wid, wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bvalid,
    output bready
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst,
    input  arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata, rvalid,
    input  rready,
    input  awid, awaddr, awlen, awsize, awburst,
    input  awlock, awcache, awprot, awvalid,
    output awready,
    input  wid, wdata, wstrb, wlast, wvalid,
    output wready,
    output bvalid,
    input  bready
  );

endinterface

// File: rtl/axi_size_dec.sv
// Store strobe to AXI size and low address bits.
// Unsupported strobe patterns fall back to a word access.
module axi_size_dec
  import cpu_axi_pkg::*;
(
  input  logic [3:0] wen,
  output logic [2:0] size,
  output logic [1:0] offset
);

  always_comb begin
    size   = SIZE_W;
    offset = 2'd0;
    unique case (1'b1)
      (wen == 4'b1111): begin size = SIZE_W; offset = 2'd0; end
      (wen == 4'b1100): begin size = SIZE_H; offset = 2'd2; end
      (wen == 4'b0011): begin size = SIZE_H; offset = 2'd0; end
      (wen == 4'b1000): begin size = SIZE_B; offset = 2'd3; end
      (wen == 4'b0100): begin size = SIZE_B; offset = 2'd2; end
      (wen == 4'b0010): begin size = SIZE_B; offset = 2'd1; end
      (wen == 4'b0001): begin size = SIZE_B; offset = 2'd0; end
      default: ;
    endcase
  end

endmodule

// File: rtl/cpu_axi_bridge.sv
// SRAM-style core ports to one single-beat AXI3 master.
// One transaction in flight; data before fetch; core stalled meanwhile.
module cpu_axi_bridge
  import cpu_axi_pkg::*;
#(
  parameter logic [3:0] ID_INST = ID_INST_DFLT,
  parameter logic [3:0] ID_DATA = ID_DATA_DFLT
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_sram_en,
  input  logic [3:0]  inst_sram_wen,
  input  logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_wdata,
  output logic [31:0] inst_sram_rdata,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic        stallreq,
  cpu_axi_bridge_if.master axi
);

  state_t      state, state_d;
  logic        pend_i;
  logic [31:0] d_addr_q, d_wdata_q, i_addr_q;
  logic [3:0]  d_wen_q;
  logic        aw_done, w_done;
  logic [31:0] inst_rdata_q, data_rdata_q;
  logic [2:0]  aw_size;
  logic [1:0]  aw_off;
  logic        unused_in;

  assign unused_in = ^{inst_sram_wen, inst_sram_wdata};

  axi_size_dec u_size_dec (
    .wen    (d_wen_q),
    .size   (aw_size),
    .offset (aw_off)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= IDLE;
      pend_i       <= 1'b0;
      d_addr_q     <= '0;
      d_wdata_q    <= '0;
      d_wen_q      <= '0;
      i_addr_q     <= '0;
      aw_done      <= 1'b0;
      w_done       <= 1'b0;
      inst_rdata_q <= '0;
      data_rdata_q <= '0;
    end else begin
      state <= state_d;
      if (state == IDLE) begin
        pend_i <= data_sram_en & inst_sram_en;
        if (data_sram_en) begin
          d_addr_q  <= data_sram_addr;
          d_wen_q   <= data_sram_wen;
          d_wdata_q <= data_sram_wdata;
        end
        if (inst_sram_en)
          i_addr_q <= inst_sram_addr;
      end
      // AW and W complete independently; remember which one is done
      if (state == D_AW) begin
        if (axi.awready) aw_done <= 1'b1;
        if (axi.wready)  w_done  <= 1'b1;
      end else begin
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end
      if (state == D_R && axi.rvalid)
        data_rdata_q <= axi.rdata;
      if (state == I_R && axi.rvalid)
        inst_rdata_q <= axi.rdata;
    end
  end

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE: begin
        if (data_sram_en)
          state_d = (|data_sram_wen) ? D_AW : D_AR;
        else if (inst_sram_en)
          state_d = I_AR;
      end
      D_AR: if (axi.arready) state_d = D_R;
      I_AR: if (axi.arready) state_d = I_R;
      D_R:  if (axi.rvalid) state_d = pend_i ? I_AR : DONE;
      I_R:  if (axi.rvalid) state_d = DONE;
      D_AW: begin
        if ((aw_done | axi.awready) && (w_done | axi.wready))
          state_d = D_B;
      end
      D_B:  if (axi.bvalid) state_d = pend_i ? I_AR : DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign stallreq = resetn & ((state == IDLE) ?
                    (inst_sram_en | data_sram_en) :
                    (state != DONE));

  assign inst_sram_rdata = inst_rdata_q;
  assign data_sram_rdata = data_rdata_q;

  assign axi.arid    = (state == I_AR) ? ID_INST : ID_DATA;
  assign axi.araddr  = (state == I_AR) ? i_addr_q : d_addr_q;
  assign axi.arlen   = LEN_1;
  assign axi.arsize  = SIZE_W;
  assign axi.arburst = BURST_INCR;
  assign axi.arlock  = 2'b00;
  assign axi.arcache = 4'b0000;
  assign axi.arprot  = 3'b000;
  assign axi.arvalid = (state == D_AR) || (state == I_AR);
  assign axi.rready  = (state == D_R) || (state == I_R);

  assign axi.awid    = ID_DATA;
  assign axi.awaddr  = {d_addr_q[31:2], aw_off};
  assign axi.awlen   = LEN_1;
  assign axi.awsize  = aw_size;
  assign axi.awburst = BURST_INCR;
  assign axi.awlock  = 2'b00;
  assign axi.awcache = 4'b0000;
  assign axi.awprot  = 3'b000;
  assign axi.awvalid = (state == D_AW) && !aw_done;

  assign axi.wid     = ID_DATA;
  assign axi.wdata   = d_wdata_q;
  assign axi.wstrb   = d_wen_q;
  assign axi.wlast   = 1'b1;
  assign axi.wvalid  = (state == D_AW) && !w_done;
  assign axi.bready  = (state == D_B);

  // IDs are not used for routing, but a stray one means a broken slave
  always_ff @(posedge clk) begin
    if (resetn && axi.rvalid && axi.rready)
      assert (axi.rid == ((state == I_R) ? ID_INST : ID_DATA));
  end

endmodule

// File: tb/tb_cpu_axi_bridge.sv
// Bench for cpu_axi_bridge: table of core requests, AXI slave
// model with programmable delays, and an expected-transaction queue.
module tb_cpu_axi_bridge;
  import cpu_axi_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        inst_sram_en = 1'b0;
  logic [3:0]  inst_sram_wen = '0;
  logic [31:0] inst_sram_addr = '0;
  logic [31:0] inst_sram_wdata = '0;
  logic [31:0] inst_sram_rdata;
  logic        data_sram_en = 1'b0;
  logic [3:0]  data_sram_wen = '0;
  logic [31:0] data_sram_addr = '0;
  logic [31:0] data_sram_wdata = '0;
  logic [31:0] data_sram_rdata;
  logic        stallreq;

  cpu_axi_bridge_if axi();

  cpu_axi_bridge #(
    .ID_INST (4'd0),
    .ID_DATA (4'd1)
  ) dut (
    .clk             (clk),
    .resetn          (rst_n),
    .inst_sram_en    (inst_sram_en),
    .inst_sram_wen   (inst_sram_wen),
    .inst_sram_addr  (inst_sram_addr),
    .inst_sram_wdata (inst_sram_wdata),
    .inst_sram_rdata (inst_sram_rdata),
    .data_sram_en    (data_sram_en),
    .data_sram_wen   (data_sram_wen),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata),
    .data_sram_rdata (data_sram_rdata),
    .stallreq        (stallreq),
    .axi             (axi)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (a == 32'hBFC0_0000) return 32'h3C1D_BFC0;
    return a ^ 32'hA5A5_0F0F;
  endfunction

  typedef struct {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [2:0]  size;
  } addr_exp_t;

  typedef struct {
    logic [3:0]  strb;
    logic [31:0] data;
  } w_exp_t;

  addr_exp_t aq[$];
  w_exp_t    wq[$];
  int ar_hs = 0;
  int aw_hs = 0;
  int ar_dly = 0;
  int r_dly = 0;
  int aw_dly = 0;
  int w_dly = 0;
  logic [31:0] exp_drd = '0;
  logic [31:0] exp_ird = '0;

  // AXI slave model, acting at negedges
  initial begin
    bit          r_pend, aw_ok, w_ok, ar_prev;
    int          ar_cnt, r_cnt, aw_cnt, w_cnt;
    logic [31:0] r_addr, ar_prev_addr;
    logic [3:0]  r_id;
    addr_exp_t   e;
    w_exp_t      we;
    r_pend = 0; aw_ok = 0; w_ok = 0; ar_prev = 0;
    ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0;
    r_addr = '0; ar_prev_addr = '0; r_id = '0;
    axi.arready = 0; axi.rvalid = 0; axi.rid = '0;
    axi.rdata = '0; axi.awready = 0; axi.wready = 0;
    axi.bvalid = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        axi.arready = 0; axi.rvalid = 0; axi.awready = 0;
        axi.wready = 0; axi.bvalid = 0;
        r_pend = 0; aw_ok = 0; w_ok = 0; ar_prev = 0;
        ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0;
        continue;
      end
      if (ar_prev) begin
        check("ar_hold", axi.arvalid, 1);
        check("ar_stable", axi.araddr, ar_prev_addr);
        ar_prev = 0;
      end
      if (axi.rvalid) axi.rvalid = 0;
      if (axi.arready) begin
        axi.arready = 0; r_pend = 1; r_cnt = 0;
      end
      if (r_pend) begin
        if (r_cnt >= r_dly) begin
          axi.rvalid = 1;
          axi.rdata = mem_rd(r_addr);
          axi.rid = r_id;
          r_pend = 0;
        end else r_cnt++;
      end
      if (axi.arvalid && !axi.arready) begin
        if (ar_cnt >= ar_dly) begin
          axi.arready = 1; ar_cnt = 0; ar_hs++;
          r_addr = axi.araddr; r_id = axi.arid;
          if (aq.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL unexpected_ar: got %h want none", axi.araddr);
          end else begin
            e = aq.pop_front();
            check("arid", axi.arid, e.id);
            check("araddr", axi.araddr, e.addr);
            check("arsize", axi.arsize, e.size);
          end
        end else begin
          ar_cnt++; ar_prev = 1; ar_prev_addr = axi.araddr;
        end
      end
      if (axi.awready) begin axi.awready = 0; aw_ok = 1; end
      if (axi.awvalid && !axi.awready && !aw_ok) begin
        if (aw_cnt >= aw_dly) begin
          axi.awready = 1; aw_cnt = 0; aw_hs++;
          if (aq.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL unexpected_aw: got %h want none", axi.awaddr);
          end else begin
            e = aq.pop_front();
            check("awid", axi.awid, e.id);
            check("awaddr", axi.awaddr, e.addr);
            check("awsize", axi.awsize, e.size);
          end
        end else aw_cnt++;
      end
      if (axi.wready) begin axi.wready = 0; w_ok = 1; end
      if (axi.wvalid && !axi.wready && !w_ok) begin
        if (w_cnt >= w_dly) begin
          axi.wready = 1; w_cnt = 0;
          if (wq.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL unexpected_w: got %h want none", axi.wdata);
          end else begin
            we = wq.pop_front();
            check("wstrb", axi.wstrb, we.strb);
            check("wdata", axi.wdata, we.data);
            check("wlast", axi.wlast, 1);
          end
        end else w_cnt++;
      end
      if (axi.bvalid) axi.bvalid = 0;
      else if (aw_ok && w_ok) begin
        axi.bvalid = 1; aw_ok = 0; w_ok = 0;
      end
    end
  end

  typedef struct {
    bit          d_en;
    logic [3:0]  wen;
    logic [31:0] daddr;
    logic [31:0] wdata;
    bit          i_en;
    logic [31:0] iaddr;
    int          ar_d;
    int          aw_d;
    int          w_d;
    logic [31:0] awaddr;
    logic [2:0]  awsize;
    int          stall;
  } vec_t;

  task automatic run_req(input bit d_en, input logic [3:0] wen,
                         input logic [31:0] daddr,
                         input logic [31:0] wdata,
                         input bit i_en, input logic [31:0] iaddr,
                         input logic [31:0] exp_awaddr,
                         input logic [2:0] exp_awsize,
                         input int exp_stall, input string tag);
    int ar0, aw0, cyc, exp_ar, exp_aw;
    ar0 = ar_hs; aw0 = aw_hs; cyc = 0;
    exp_ar = 0; exp_aw = 0;
    if (d_en && wen != 4'd0) begin
      aq.push_back('{4'd1, exp_awaddr, exp_awsize});
      wq.push_back('{wen, wdata});
      exp_aw = 1;
    end else if (d_en) begin
      aq.push_back('{4'd1, daddr, SIZE_W});
      exp_drd = mem_rd(daddr);
      exp_ar++;
    end
    if (i_en) begin
      aq.push_back('{4'd0, iaddr, SIZE_W});
      exp_ird = mem_rd(iaddr);
      exp_ar++;
    end
    data_sram_en = d_en; data_sram_wen = wen;
    data_sram_addr = daddr; data_sram_wdata = wdata;
    inst_sram_en = i_en; inst_sram_addr = iaddr;
    #1;
    while (stallreq && cyc < 300) begin
      cyc++;
      @(posedge clk);
      #1;
    end
    if (cyc >= 300) begin
      n_vec++; n_err++;
      $display("FAIL %s_timeout: got stall>=%0d want %0d", tag, cyc, exp_stall);
    end
    check({tag, "_stall"}, cyc, exp_stall);
    @(posedge clk);
    #1;
    data_sram_en = 0; inst_sram_en = 0;
    check({tag, "_ar_cnt"}, ar_hs - ar0, exp_ar);
    check({tag, "_aw_cnt"}, aw_hs - aw0, exp_aw);
    check({tag, "_drd"}, data_sram_rdata, exp_drd);
    check({tag, "_ird"}, inst_sram_rdata, exp_ird);
  endtask

  initial begin
    vec_t tbl[11];
    int   n, ar0;
    tbl[0]  = '{0, 4'b0000, 32'h0, 32'h0, 1, 32'hBFC0_0000,
                0, 0, 0, 32'h0, 3'd0, 3};
    tbl[1]  = '{1, 4'b0000, 32'h8000_1000, 32'h0, 1, 32'hBFC0_0004,
                0, 0, 0, 32'h0, 3'd0, 5};
    tbl[2]  = '{1, 4'b0100, 32'h8000_0010, 32'h00AB_0000, 0, 32'h0,
                0, 3, 0, 32'h8000_0012, 3'd0, 6};
    tbl[3]  = '{1, 4'b1100, 32'h8000_0020, 32'h1234_0000, 0, 32'h0,
                0, 0, 2, 32'h8000_0022, 3'd1, 5};
    tbl[4]  = '{1, 4'b0011, 32'h8000_0034, 32'h0000_5678, 0, 32'h0,
                0, 0, 0, 32'h8000_0034, 3'd1, 3};
    tbl[5]  = '{1, 4'b1111, 32'h8000_004C, 32'hDEAD_BEEF, 1, 32'hBFC0_0008,
                0, 1, 2, 32'h8000_004C, 3'd2, 7};
    tbl[6]  = '{1, 4'b0001, 32'h8000_0051, 32'h0000_00EE, 0, 32'h0,
                0, 0, 0, 32'h8000_0050, 3'd0, 3};
    tbl[7]  = '{1, 4'b1000, 32'h8000_0060, 32'h9900_0000, 0, 32'h0,
                0, 0, 0, 32'h8000_0063, 3'd0, 3};
    tbl[8]  = '{1, 4'b0010, 32'h8000_0070, 32'h0000_CC00, 0, 32'h0,
                0, 0, 0, 32'h8000_0071, 3'd0, 3};
    tbl[9]  = '{0, 4'b0000, 32'h0, 32'h0, 1, 32'hBFC0_0010,
                10, 0, 0, 32'h0, 3'd0, 13};
    tbl[10] = '{1, 4'b0000, 32'h8000_2000, 32'h0, 0, 32'h0,
                2, 0, 0, 32'h0, 3'd0, 5};

    repeat (3) @(negedge clk);
    check("rst_arvalid", axi.arvalid, 0);
    check("rst_awvalid", axi.awvalid, 0);
    check("rst_wvalid", axi.wvalid, 0);
    check("rst_rready", axi.rready, 0);
    check("rst_bready", axi.bready, 0);
    check("rst_stall", stallreq, 0);
    check("rst_drd", data_sram_rdata, 0);
    check("rst_ird", inst_sram_rdata, 0);
    check("rst_araddr", axi.araddr, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_stall", stallreq, 0);

    foreach (tbl[i]) begin
      @(negedge clk);
      ar_dly = tbl[i].ar_d; aw_dly = tbl[i].aw_d; w_dly = tbl[i].w_d;
      run_req(tbl[i].d_en, tbl[i].wen, tbl[i].daddr, tbl[i].wdata,
              tbl[i].i_en, tbl[i].iaddr, tbl[i].awaddr, tbl[i].awsize,
              tbl[i].stall, $sformatf("vec%0d", i));
    end
    ar_dly = 0; aw_dly = 0; w_dly = 0;

    // Back-to-back fetches: next address presented right after DONE
    @(negedge clk);
    ar0 = ar_hs;
    run_req(0, 4'd0, 32'h0, 32'h0, 1, 32'hBFC0_0100,
            32'h0, 3'd0, 3, "b2b_a");
    run_req(0, 4'd0, 32'h0, 32'h0, 1, 32'hBFC0_0104,
            32'h0, 3'd0, 3, "b2b_b");
    repeat (4) @(negedge clk);
    check("b2b_total_ar", ar_hs - ar0, 2);

    // Reset while a load waits in the R phase
    @(negedge clk);
    r_dly = 4;
    aq.push_back('{4'd1, 32'h8000_3000, SIZE_W});
    data_sram_en = 1; data_sram_wen = 4'd0;
    data_sram_addr = 32'h8000_3000;
    n = 0;
    while (!axi.rready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("mid_reach_r", axi.rready, 1);
    #1 rst_n = 1'b0;
    #1;
    check("mid_arvalid", axi.arvalid, 0);
    check("mid_rready", axi.rready, 0);
    check("mid_awvalid", axi.awvalid, 0);
    check("mid_wvalid", axi.wvalid, 0);
    check("mid_bready", axi.bready, 0);
    check("mid_stall", stallreq, 0);
    check("mid_drd", data_sram_rdata, 0);
    check("mid_ird", inst_sram_rdata, 0);
    exp_drd = '0; exp_ird = '0;
    aq.delete(); wq.delete();
    data_sram_en = 0; r_dly = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_stall", stallreq, 0);
    run_req(0, 4'd0, 32'h0, 32'h0, 1, 32'hBFC0_0000,
            32'h0, 3'd0, 3, "post_rst");

    repeat (4) @(negedge clk);
    check("sb_empty", aq.size(), 0);
    check("wq_empty", wq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end want finish");
    $fatal(1);
  end

endmodule
